noc_vc_output_arbiter: RTL and testbench



---
 rtl/noc_vc_output_arbiter.sv | 154 +++++++++++++++
 tb/tb_noc_vc_output_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_output_arbiter.sv
// Round-robin, packet-granular arbiter that shares one NoC output link between local sources.
// Each packet rides one of two credit-gated virtual channels, chosen at grant time.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_vc_output_arbiter #(
    parameter int NUM_IN       = 4,
    parameter int FLIT_W       = `Noc_Data_Width,
    parameter int CREDIT_DEPTH = 4,
    parameter int CNT_W        = 3
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    input  logic [NUM_IN-1:0]        in_is_header,
    input  logic [NUM_IN-1:0]        in_is_tail,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_is_header,
    output logic                     out_is_tail,
    output logic                     out_vc,
    input  logic [1:0]               credit_return,
    output logic                     busy,
    output logic [2:0]               owner,
    output logic                     protocol_err
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            r_state, w_stateNext;
    logic [PTR_W-1:0]  r_rrPtr, r_owner, w_winner, w_scanIdx, w_rrNext;
    logic              r_curVc, r_firstDone, r_protocolErr;
    logic [CNT_W-1:0]  r_credit0, r_credit1;
    logic              w_winnerFound, w_credOk, w_anyCredit, w_grant;
    logic              w_idleBodyErr, w_hdrErr, w_xfer0, w_xfer1, w_ovf0, w_ovf1;
    logic [NUM_IN-1:0] w_cand;
    logic [FLIT_W-1:0] w_flitArr [NUM_IN];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_flitArr[i] = in_flit[i*FLIT_W +: FLIT_W];
        end
    end

    // Only headers may compete; the scan starts at the requester after the last packet owner.
    always_comb begin
        w_cand        = in_valid & in_is_header;
        w_winner      = '0;
        w_winnerFound = 1'b0;
        w_scanIdx     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_scanIdx = PTR_W'((int'(r_rrPtr) + k) % NUM_IN);
            if (!w_winnerFound && w_cand[w_scanIdx]) begin
                w_winnerFound = 1'b1;
                w_winner      = w_scanIdx;
            end
        end
    end

    assign w_credOk    = r_curVc ? (r_credit1 != '0) : (r_credit0 != '0);
    assign w_anyCredit = (r_credit0 != '0) || (r_credit1 != '0);
    assign w_rrNext    = (r_owner == PTR_W'(NUM_IN - 1)) ? '0 : r_owner + PTR_W'(1);

    // Link outputs are gated by reset so an abandoned packet never leaks a flit.
    always_comb begin
        w_stateNext   = r_state;
        w_grant       = 1'b0;
        w_idleBodyErr = 1'b0;
        in_ready      = '0;
        out_valid     = 1'b0;
        out_flit      = '0;
        out_is_header = 1'b0;
        out_is_tail   = 1'b0;
        out_vc        = 1'b0;
        if (!noc_rst) begin
            case (r_state)
                IDLE: begin
                    w_idleBodyErr = |(in_valid & ~in_is_header);
                    if (w_winnerFound && w_anyCredit) begin
                        w_grant     = 1'b1;
                        w_stateNext = SEND;
                    end
                end
                SEND: begin
                    in_ready[r_owner] = w_credOk;
                    out_valid         = in_valid[r_owner] && w_credOk;
                    out_flit          = w_flitArr[r_owner];
                    out_is_header     = in_is_header[r_owner];
                    out_is_tail       = in_is_tail[r_owner];
                    out_vc            = r_curVc;
                    if (out_valid && out_is_tail) begin
                        w_stateNext = IDLE;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    assign w_hdrErr     = out_valid && out_is_header && r_firstDone;
    assign w_xfer0      = out_valid && !r_curVc;
    assign w_xfer1      = out_valid && r_curVc;
    assign w_ovf0       = credit_return[0] && !w_xfer0 && (r_credit0 == CREDIT_MAX);
    assign w_ovf1       = credit_return[1] && !w_xfer1 && (r_credit1 == CREDIT_MAX);
    assign busy         = !noc_rst && (r_state == SEND);
    assign owner        = noc_rst ? 3'd0 : 3'(r_owner);
    assign protocol_err = !noc_rst && r_protocolErr;

    // A transfer and a return on the same VC cancel; overflowing returns saturate.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_state       <= IDLE;
            r_rrPtr       <= '0;
            r_owner       <= '0;
            r_curVc       <= 1'b0;
            r_firstDone   <= 1'b0;
            r_credit0     <= CREDIT_MAX;
            r_credit1     <= CREDIT_MAX;
            r_protocolErr <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_grant) begin
                r_owner     <= w_winner;
                r_curVc     <= (r_credit0 == '0);
                r_firstDone <= 1'b0;
            end else if (out_valid) begin
                r_firstDone <= 1'b1;
            end
            if (out_valid && out_is_tail) begin
                r_rrPtr <= w_rrNext;
            end
            if (w_xfer0 && !credit_return[0]) begin
                r_credit0 <= r_credit0 - CNT_W'(1);
            end else if (!w_xfer0 && credit_return[0] && !w_ovf0) begin
                r_credit0 <= r_credit0 + CNT_W'(1);
            end
            if (w_xfer1 && !credit_return[1]) begin
                r_credit1 <= r_credit1 - CNT_W'(1);
            end else if (!w_xfer1 && credit_return[1] && !w_ovf1) begin
                r_credit1 <= r_credit1 + CNT_W'(1);
            end
            if (w_idleBodyErr || w_hdrErr || w_ovf0 || w_ovf1) begin
                r_protocolErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_vc_output_arbiter.sv
// Directed bench: per-requester source queues feed the arbiter, and a scoreboard of
// expected link flits (in predicted round-robin order) is popped whenever out_valid is seen.
module tb_noc_vc_output_arbiter;

    localparam int NUM_IN = 4;
    localparam int FLIT_W = 32;

    typedef struct packed {
        logic [FLIT_W-1:0] flit;
        logic              hdr;
        logic              tail;
        logic              vc;
    } flit_t;

    logic                     noc_clk;
    logic                     noc_rst;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*FLIT_W-1:0] in_flit;
    logic [NUM_IN-1:0]        in_is_header;
    logic [NUM_IN-1:0]        in_is_tail;
    logic                     out_valid;
    logic [FLIT_W-1:0]        out_flit;
    logic                     out_is_header;
    logic                     out_is_tail;
    logic                     out_vc;
    logic [1:0]               credit_return;
    logic                     busy;
    logic [2:0]               owner;
    logic                     protocol_err;

    flit_t srcQ [NUM_IN][$];
    flit_t sbQ [$];

    int nAssert = 0;
    int nFail   = 0;
    logic [1:0]        crPulse = 2'b00;
    logic              echo    = 1'b0;
    logic              sValid, sBusy, sErr;
    logic [2:0]        sOwner;
    logic [NUM_IN-1:0] sReady;
    logic [FLIT_W-1:0] sFlit;

    noc_vc_output_arbiter #(
        .NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CREDIT_DEPTH(4), .CNT_W(3)
    ) dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .in_is_header(in_is_header), .in_is_tail(in_is_tail),
        .out_valid(out_valid), .out_flit(out_flit),
        .out_is_header(out_is_header), .out_is_tail(out_is_tail), .out_vc(out_vc),
        .credit_return(credit_return), .busy(busy), .owner(owner),
        .protocol_err(protocol_err)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source flit k of a packet; only the first nExp flits are expected on the link.
    task automatic loadPacket(input int src, input int len, input int nExp,
                              input logic vc, input logic [FLIT_W-1:0] base,
                              input logic dupHdr);
        flit_t f;
        for (int k = 0; k < len; k++) begin
            f.flit = base + FLIT_W'(k);
            f.hdr  = (k == 0) || (dupHdr && k == 1);
            f.tail = (k == len - 1);
            f.vc   = vc;
            srcQ[src].push_back(f);
            if (k < nExp) sbQ.push_back(f);
        end
    endtask

    task automatic expectFlit(input int src, input int idx, input logic vc);
        flit_t f;
        f    = srcQ[src][idx];
        f.vc = vc;
        sbQ.push_back(f);
    endtask

    task automatic clearSources();
        for (int i = 0; i < NUM_IN; i++) srcQ[i].delete();
    endtask

    task automatic applyStimulus();
        flit_t e;
        for (int i = 0; i < NUM_IN; i++) begin
            if (srcQ[i].size() > 0) begin
                in_valid[i]                  = 1'b1;
                in_flit[i*FLIT_W +: FLIT_W]  = srcQ[i][0].flit;
                in_is_header[i]              = srcQ[i][0].hdr;
                in_is_tail[i]                = srcQ[i][0].tail;
            end else begin
                in_valid[i]                  = 1'b0;
                in_flit[i*FLIT_W +: FLIT_W]  = '0;
                in_is_header[i]              = 1'b0;
                in_is_tail[i]                = 1'b0;
            end
        end
        credit_return = crPulse;
        #1;
        if (echo && out_valid) credit_return[out_vc] = 1'b1;
        sValid = out_valid;
        sBusy  = busy;
        sErr   = protocol_err;
        sOwner = owner;
        sReady = in_ready;
        sFlit  = out_flit;
        if (out_valid) begin
            if (sbQ.size() == 0) begin
                chk("unexpectedFlit", out_valid, 1'b0);
            end else begin
                e = sbQ.pop_front();
                chk("flitData", out_flit, e.flit);
                chk("flitHdr", out_is_header, e.hdr);
                chk("flitTail", out_is_tail, e.tail);
                chk("flitVc", out_vc, e.vc);
            end
        end
        @(posedge noc_clk);
        for (int i = 0; i < NUM_IN; i++) begin
            if (sReady[i] && in_valid[i]) void'(srcQ[i].pop_front());
        end
        crPulse = 2'b00;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_sbEmpty"}, sbQ.size(), 0);
    endtask

    task automatic doReset();
        noc_rst = 1'b1;
        clearSources();
        sbQ.delete();
        echo = 1'b0;
        run(2);
        noc_rst = 1'b0;
    endtask

    initial begin
        in_valid = '0; in_flit = '0; in_is_header = '0; in_is_tail = '0;
        credit_return = '0;

        // Reset state
        doReset();
        chk("rstValid", sValid, 1'b0);
        chk("rstBusy", sBusy, 1'b0);
        chk("rstOwner", sOwner, 3'd0);
        chk("rstReady", sReady, 4'b0000);
        chk("rstErr", sErr, 1'b0);
        chk("rstFlit", sFlit, 32'h0);

        // Round-robin: 0 then 2, then rr_ptr=3 so 3 wins over 0
        echo = 1'b1;
        loadPacket(0, 3, 3, 1'b0, 32'h0000_0100, 1'b0);
        loadPacket(2, 3, 3, 1'b0, 32'h0000_0200, 1'b0);
        applyStimulus();
        chk("rrArbValid", sValid, 1'b0);
        chk("rrArbBusy", sBusy, 1'b0);
        applyStimulus();
        chk("rrOwner0", sOwner, 3'd0);
        chk("rrReady0", sReady, 4'b0001);
        chk("rrBusy0", sBusy, 1'b1);
        run(2);
        applyStimulus();
        chk("rrGapValid", sValid, 1'b0);
        chk("rrGapBusy", sBusy, 1'b0);
        applyStimulus();
        chk("rrOwner2", sOwner, 3'd2);
        run(2);
        loadPacket(3, 1, 1, 1'b0, 32'h0000_0300, 1'b0);
        loadPacket(0, 1, 1, 1'b0, 32'h0000_0400, 1'b0);
        applyStimulus();
        applyStimulus();
        chk("rrOwner3", sOwner, 3'd3);
        applyStimulus();
        applyStimulus();
        chk("rrOwnerWrap", sOwner, 3'd0);
        applyStimulus();
        checkOutput("rr");

        // Credit stall on VC0
        doReset();
        loadPacket(1, 6, 4, 1'b0, 32'h0000_1000, 1'b0);
        run(5);
        applyStimulus();
        chk("stallValid", sValid, 1'b0);
        chk("stallReady", sReady, 4'b0000);
        chk("stallBusy", sBusy, 1'b1);
        crPulse = 2'b01;
        applyStimulus();
        chk("stallRetValid", sValid, 1'b0);
        expectFlit(1, 0, 1'b0);
        applyStimulus();
        crPulse = 2'b01;
        applyStimulus();
        chk("stall2Valid", sValid, 1'b0);
        expectFlit(1, 0, 1'b0);
        applyStimulus();
        applyStimulus();
        chk("stallDoneBusy", sBusy, 1'b0);
        checkOutput("stall");

        // VC fallback with credit0=0: first packet uses VC1 fully, second stalls on VC1
        loadPacket(0, 2, 2, 1'b1, 32'h0000_2000, 1'b0);
        run(4);
        loadPacket(3, 3, 2, 1'b1, 32'h0000_2100, 1'b0);
        run(3);
        applyStimulus();
        chk("vcStallValid", sValid, 1'b0);
        crPulse = 2'b01;
        applyStimulus();
        applyStimulus();
        chk("vcFixedValid", sValid, 1'b0);
        chk("vcFixedOwner", sOwner, 3'd3);
        crPulse = 2'b10;
        applyStimulus();
        expectFlit(3, 0, 1'b1);
        applyStimulus();
        applyStimulus();
        chk("vcErr", sErr, 1'b0);
        checkOutput("vc");

        // Single-flit packet with simultaneous return keeps credit0 at 4
        doReset();
        loadPacket(2, 1, 1, 1'b0, 32'h0000_3000, 1'b0);
        applyStimulus();
        crPulse = 2'b01;
        applyStimulus();
        applyStimulus();
        chk("singleIdle", sBusy, 1'b0);
        chk("singleErr", sErr, 1'b0);
        loadPacket(1, 5, 4, 1'b0, 32'h0000_3100, 1'b0);
        run(5);
        applyStimulus();
        chk("singleCreditStall", sValid, 1'b0);
        checkOutput("single");

        // Overflowing return sets error and saturates credit1 at 4
        doReset();
        crPulse = 2'b10;
        applyStimulus();
        applyStimulus();
        chk("ovfErr", sErr, 1'b1);
        loadPacket(0, 4, 4, 1'b0, 32'h0000_4000, 1'b0);
        run(6);
        loadPacket(1, 5, 4, 1'b1, 32'h0000_4100, 1'b0);
        run(5);
        applyStimulus();
        chk("ovfSatStall", sValid, 1'b0);
        chk("ovfErrSticky", sErr, 1'b1);
        checkOutput("ovf");

        // Body flit in IDLE
        doReset();
        applyStimulus();
        chk("bodyErrClear", sErr, 1'b0);
        srcQ[3].push_back('{flit: 32'h0000_5000, hdr: 1'b0, tail: 1'b0, vc: 1'b0});
        applyStimulus();
        chk("bodyReady", sReady, 4'b0000);
        chk("bodyValid", sValid, 1'b0);
        applyStimulus();
        chk("bodyErr", sErr, 1'b1);
        clearSources();
        applyStimulus();
        chk("bodyErrSticky", sErr, 1'b1);

        // Repeated header inside a packet
        doReset();
        loadPacket(0, 3, 3, 1'b0, 32'h0000_6000, 1'b1);
        run(2);
        applyStimulus();
        chk("dupHdrBefore", sErr, 1'b0);
        run(2);
        chk("dupHdrErr", sErr, 1'b1);
        checkOutput("dupHdr");

        // Reset mid-packet
        doReset();
        loadPacket(2, 5, 2, 1'b0, 32'h0000_7000, 1'b0);
        run(3);
        noc_rst = 1'b1;
        applyStimulus();
        chk("midRstValid", sValid, 1'b0);
        chk("midRstBusy", sBusy, 1'b0);
        chk("midRstReady", sReady, 4'b0000);
        clearSources();
        noc_rst = 1'b0;
        applyStimulus();
        chk("postRstValid", sValid, 1'b0);
        chk("postRstOwner", sOwner, 3'd0);
        chk("postRstFlit", sFlit, 32'h0);
        loadPacket(1, 5, 4, 1'b0, 32'h0000_7100, 1'b0);
        applyStimulus();
        applyStimulus();
        chk("postRstOwner1", sOwner, 3'd1);
        run(3);
        applyStimulus();
        chk("postRstCredit", sValid, 1'b0);
        checkOutput("midRst");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
